// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: packs decoded micro-op descriptors into 32-bit
// instruction words and streams them into instruction memory at consecutive addresses.
module rv32_instr_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_class,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  sub,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic [15:0] word_count,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_I      = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_LUI    = 3'd5;
  localparam logic [2:0] CLS_JAL    = 3'd6;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_SLL = 4'd1;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_SUB = 4'd9;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Handshake: a descriptor transfers on any rising edge where in_valid && in_ready;
  // a memory write completes on any rising edge where imem_we && imem_ready.
  // in_ready depends only on the output stage and imem_ready, never on in_valid.

  logic        stage_valid;
  logic [31:0] stage_wdata;
  logic [31:0] addr_q;
  logic [15:0] word_count_q;
  logic        err_q;
  logic [7:0]  err_count_q;

  logic        accept;
  logic        write_done;
  logic [31:0] addr_next;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic [2:0]  alu_f3;
  logic        alu_bad;
  logic        is_shift;
  logic [6:0]  r_f7;
  logic [6:0] i_f7;

  assign in_ready   = !stage_valid || imem_ready;
  assign accept     = in_valid && in_ready;
  assign write_done = stage_valid && imem_ready;
  assign addr_next  = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;

  // ALU code to func3; sub shares add's func3 and sra shares srl's.
  always_comb begin
    alu_f3 = 3'b000;
    case (alu_op)
      4'd0:    alu_f3 = 3'b000;
      4'd1:    alu_f3 = 3'b001;
      4'd2:    alu_f3 = 3'b010;
      4'd3:    alu_f3 = 3'b011;
      4'd4:    alu_f3 = 3'b100;
      4'd5:    alu_f3 = 3'b101;
      4'd6:    alu_f3 = 3'b101;
      4'd7:    alu_f3 = 3'b110;
      4'd8:    alu_f3 = 3'b111;
      4'd9:    alu_f3 = 3'b000;
      default: alu_f3 = 3'b000;
    endcase
  end

  assign alu_bad  = alu_op > 4'd9;
  assign is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign r_f7     = ((alu_op == ALU_SUB) || (alu_op == ALU_SRA)) ? F7_ALT : 7'd0;
  assign i_f7     = (alu_op == ALU_SRA) ? F7_ALT : 7'd0;

  always_comb begin
    enc_word    = 32'd0;
    enc_illegal = 1'b0;
    case (op_class)
      CLS_R: begin
        enc_word    = {r_f7, rs2, rs1, alu_f3, rd, OPC_R};
        enc_illegal = alu_bad;
      end
      CLS_I: begin
        if (is_shift) begin
          enc_word    = {i_f7, imm[4:0], rs1, alu_f3, rd, OPC_I};
          enc_illegal = imm[11:5] != 7'd0;
        end else begin
          enc_word    = {imm[11:0], rs1, alu_f3, rd, OPC_I};
          enc_illegal = alu_bad || (alu_op == ALU_SUB);
        end
      end
      CLS_LOAD: begin
        enc_word    = {imm[11:0], rs1, sub, rd, OPC_LOAD};
        enc_illegal = (sub == 3'b011) || (sub == 3'b110) || (sub == 3'b111);
      end
      CLS_STORE: begin
        enc_word    = {imm[11:5], rs2, rs1, sub, imm[4:0], OPC_STORE};
        enc_illegal = sub > 3'b010;
      end
      CLS_BRANCH: begin
        enc_word    = {imm[12], imm[10:5], rs2, rs1, sub, imm[4:1], imm[11], OPC_BRANCH};
        enc_illegal = (sub == 3'b010) || (sub == 3'b011) || imm[0];
      end
      CLS_LUI: begin
        enc_word    = {imm[31:12], rd, OPC_LUI};
        enc_illegal = 1'b0;
      end
      CLS_JAL: begin
        enc_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        enc_illegal = imm[0];
      end
      default: begin
        enc_word    = 32'd0;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // addr_q is the address of the word in the stage, or of the next word if empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid  <= 1'b0;
      stage_wdata  <= 32'd0;
      addr_q       <= BASE_ADDR;
      word_count_q <= 16'd0;
      err_q        <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      if (write_done) begin
        addr_q       <= addr_next;
        word_count_q <= word_count_q + 16'd1;
      end
      if (accept && !enc_illegal) begin
        stage_valid <= 1'b1;
        stage_wdata <= enc_word;
      end else if (write_done) begin
        stage_valid <= 1'b0;
      end
      if (accept && enc_illegal) begin
        err_q <= 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign imem_we    = stage_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = stage_wdata;
  assign word_count = word_count_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Sequential RV32I instruction encoder: the inverse of the core's instruction decoder. It accepts decoded micro-op descriptors (instruction class, ALU op code, sub-function, register indices, immediate) over a valid/ready handshake. It packs each descriptor into a 32-bit instruction word and writes the word into instruction memory at an auto-incrementing address. The block sits beside the boot/test-program loader, so self-test programs can be generated on-chip and written into I-memory before the cores leave reset.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- DEPTH_WORDS, 1024, number of I-memory words; the address wraps modulo this window
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- op_class  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 JAL, 7 reserved
- alu_op  in  4  decoder ALU code: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 sra, 7 or, 8 and, 9 sub
- sub  in  3  func3 for LOAD/STORE/BRANCH; ignored otherwise
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  immediate, sign-extended byte value (LUI: upper 20 bits used)
- imem_we  out  1  write request; data/address are valid while high
- imem_addr  out  32  byte address
- imem_wdata  out  32  encoded instruction
- imem_ready  in  1  memory accepts the write when imem_we && imem_ready
- word_count  out  16  words written since reset; wraps at 65535
- err  out  1  sticky: an illegal descriptor was seen since reset
- err_count  out  8  illegal descriptors; saturates at 255

## Operation
- Encoding per class:
  - R: opcode 0110011. func3 from alu_op (add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111). func7 = 0100000 for sub/sra, else 0.
  - I-ALU: opcode 0010011, same func3 map. For shifts (1, 5, 6), [24:20] = imm[4:0] and func7 = 0100000 for sra, else 0. For all others, [31:20] = imm[11:0].
  - LOAD: opcode 0000011, func3 = sub, [31:20] = imm[11:0].
  - STORE: opcode 0100011, [31:25] = imm[11:5], [11:7] = imm[4:0].
  - BRANCH: opcode 1100011, bits {imm[12], imm[10:5], rs2, rs1, sub, imm[4:1], imm[11]}.
  - LUI: opcode 0110111, [31:12] = imm[31:12].
  - JAL: opcode 1101111, bits {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
  - Unused register fields are encoded as 0.
- Illegal descriptors:
  - op_class 7, or alu_op > 9 in R/I-ALU.
  - alu_op 9 in I-ALU.
  - LOAD sub in {011, 110, 111}; STORE sub > 010; BRANCH sub in {010, 011}.
  - BRANCH/JAL with imm[0] = 1.
  - Shift immediate with imm[11:5] nonzero.
  - Handling: an illegal descriptor is still consumed (in_ready behaves normally) but is never written. err is set and err_count is incremented the next cycle. address and word_count are unchanged.
- Output stage is one register holding {valid, addr, wdata}. imem_we = stage valid.
- Address starts at BASE_ADDR and advances by 4 after each completed write. After BASE_ADDR + 4*(DEPTH_WORDS-1), it wraps to BASE_ADDR.

## Timing
- in_ready = !imem_we || imem_ready. The block is a single-stage pipeline with no combinational path from in_valid to in_ready.
- A legal descriptor accepted on edge N drives imem_we = 1 with its word from edge N, visible in cycle N+1.
- imem_we, imem_addr and imem_wdata are held stable until imem_ready. When imem_ready = 1 and a new descriptor is accepted on the same edge, the new word replaces the old one back-to-back, giving 1 word per cycle sustained.
- word_count increments on the edge on which imem_we && imem_ready.
- Reset values:
  - in_ready = 1, imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - word_count = 0, err = 0, err_count = 0.
- A reset asserted mid-write discards the pending word; no write completes on the reset edge.
- Simultaneous completed write and illegal accept: the write completes and the error counts. imem_we falls the next cycle.

## Test plan
- R add x3,x1,x2, then sub with the same registers, imem_ready = 1 → 0x002081B3 at BASE_ADDR, 0x402081B3 at BASE_ADDR+4; word_count = 2.
- I-ALU addi x1,x0,5; then srai x4,x4,3 (alu_op 6, imm 3) → 0x00500093, 0x40325213.
- STORE sw x2,8(x1); LUI x5,0x12345000; JAL x1,+8 → 0x0020A423, 0x123452B7, 0x008000EF at consecutive addresses.
- Hold imem_ready = 0 for 5 cycles with in_valid held high → in_ready = 0 and the first word is stable throughout. When imem_ready rises, the second descriptor follows with no bubble.
- Illegal descriptors: op_class 7, then JAL with imm = 3, then a legal add → no write for the first two; err = 1, err_count = 2; the add is written at BASE_ADDR. Feeding 300 illegal descriptors saturates err_count at 255.
- DEPTH_WORDS = 4: write 5 words → the fifth goes to BASE_ADDR; word_count = 5. Asserting reset while imem_we = 1 → imem_we = 0 and imem_addr = BASE_ADDR next cycle.
